// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline types: stage-register state encoding, counter width and stage payload structs.
package pipes;

   parameter int PIPE_CNT_W = 32;

   typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } decode_data_t;

   function automatic logic [1:0] ps_occupancy(input pipe_state_t s);
      case (s)
         PS_BUSY: ps_occupancy = 2'd1;
         PS_FULL: ps_occupancy = 2'd2;
         default: ps_occupancy = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush and saturating stall counter.
// Define PIPE_SKID_EN for the 2-entry skid variant with a registered in_ready.
module pipe_stage_reg
   import pipes::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = PIPE_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   pipe_state_t      r_state;
   pipe_state_t      w_next_state;
   logic [WIDTH-1:0] r_main;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_in_fire;
   logic             w_out_fire;

   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = out_valid && out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= PS_EMPTY;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (flush) begin
         w_next_state = PS_EMPTY;
      end else begin
         case (r_state)
            PS_EMPTY: if (w_in_fire) w_next_state = PS_BUSY;
            PS_BUSY: begin
`ifdef PIPE_SKID_EN
               if (w_in_fire && !w_out_fire)      w_next_state = PS_FULL;
               else if (!w_in_fire && w_out_fire) w_next_state = PS_EMPTY;
`else
               if (!w_in_fire && w_out_fire) w_next_state = PS_EMPTY;
`endif
            end
`ifdef PIPE_SKID_EN
            PS_FULL: if (w_out_fire) w_next_state = PS_BUSY;
`endif
            default: w_next_state = PS_EMPTY;
         endcase
      end
   end

   // Skid mode keeps in_ready a pure state decode so out_ready never reaches it.
   always_comb begin
      out_valid = (r_state != PS_EMPTY);
`ifdef PIPE_SKID_EN
      in_ready  = (r_state != PS_FULL);
`else
      in_ready  = !out_valid || out_ready;
`endif
      occupancy = ps_occupancy(r_state);
      out_data  = r_main;
   end

`ifdef PIPE_SKID_EN
   logic [WIDTH-1:0] r_skid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_main <= '0;
         r_skid <= '0;
      end else if (!flush) begin
         case (r_state)
            PS_EMPTY: if (w_in_fire) r_main <= in_data;
            PS_BUSY: begin
               if (w_in_fire && w_out_fire) r_main <= in_data;
               else if (w_in_fire)          r_skid <= in_data;
            end
            PS_FULL: if (w_out_fire) r_main <= r_skid;
            default: ;
         endcase
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                   r_main <= '0;
      else if (!flush && w_in_fire) r_main <= in_data;
   end
`endif

   // Flush does not clear the counter; only reset does.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall_cnt <= '0;
      else if (out_valid && !out_ready && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
   end

   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, out_ready, flush;
   logic [31:0] in_data;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [31:0] stall_cnt;
   logic        s_in_ready, s_out_valid;
   logic [31:0] s_out_data;
   logic [1:0]  s_occupancy;
   logic [3:0]  stall_cnt4;

   logic [31:0] mq[$];
   longint      mcnt;
   int          mcnt4;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(32), .CNT_W(32)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
      .occupancy(occupancy), .stall_cnt(stall_cnt));

   pipe_stage_reg #(.WIDTH(32), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .flush(flush),
      .occupancy(s_occupancy), .stall_cnt(stall_cnt4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive at posedge+1, check before the next edge, then advance the model.
   task automatic cyc(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
      bit eir, inf, outf;
      in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
      #3;
      eir = SKID ? (mq.size() < 2) : (mq.size() == 0 || ordy);
      chk("in_ready",   in_ready,   eir);
      chk("out_valid",  out_valid,  mq.size() != 0);
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
      chk("occupancy",  occupancy,  mq.size());
      chk("stall_cnt",  stall_cnt,  mcnt);
      chk("stall_cnt4", stall_cnt4, mcnt4);
      inf  = iv && eir;
      outf = (mq.size() != 0) && ordy;
      @(posedge clk);
      if (mq.size() != 0 && !ordy) begin
         if (mcnt < 64'hFFFF_FFFF) mcnt++;
         if (mcnt4 < 15) mcnt4++;
      end
      if (fl) mq.delete();
      else begin
         if (outf) void'(mq.pop_front());
         if (inf)  mq.push_back(d);
      end
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_in_ready"},  in_ready,  1'b1);
      chk({tag, "_occupancy"}, occupancy, 2'd0);
      chk({tag, "_out_data"},  out_data,  32'd0);
      chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
      chk({tag, "_stall4"},    stall_cnt4, 4'd0);
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      mcnt = 0; mcnt4 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      reset = 1'b1;

      // streaming
      cyc(1, 32'h11, 1, 0);
      cyc(1, 32'h22, 1, 0);
      cyc(1, 32'h33, 1, 0);
      repeat (3) cyc(0, 32'h0, 1, 0);

      // back-pressure: upstream holds 0xA2 until accepted
      cyc(1, 32'hA0, 0, 0);
      cyc(1, 32'hA1, 0, 0);
      cyc(1, (SKID || mq.size() == 0) ? 32'hA1 : 32'hA1, 0, 0);
      while (mq.size() != 0 && mq[$] != 32'hA1) cyc(0, 32'h0, 1, 0);
      cyc(1, 32'hA2, 0, 0);
      cyc(1, 32'hA2, 0, 0);
      repeat (5) cyc(0, 32'h0, 1, 0);

      // flush while held with input presented
      cyc(1, 32'hB0, 0, 0);
      cyc(1, 32'hB1, 0, 0);
      cyc(1, 32'hBB, 0, 1);
      cyc(0, 32'h0, 1, 0);
      cyc(0, 32'h0, 1, 0);

      // saturation: long stall then flush
      cyc(1, 32'hC0, 0, 0);
      repeat (20) cyc(0, 32'h0, 0, 0);
      cyc(0, 32'h0, 0, 1);
      cyc(0, 32'h0, 1, 0);

      // same-edge consume and accept
      cyc(1, 32'hD0, 0, 0);
      cyc(1, 32'hD1, 0, 0);
      cyc(1, 32'hD2, 1, 0);
      repeat (3) cyc(0, 32'h0, 1, 0);

      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
             $urandom_range(0, 15) == 0);

      // async reset mid-cycle while holding a payload
      cyc(1, 32'hE0, 0, 0);
      in_valid = 1'b0; out_ready = 1'b0;
      #2 reset = 1'b0;
      #1 chk_reset_vals("async");
      mq.delete(); mcnt = 0; mcnt4 = 0;
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) cyc(0, 32'h0, 1, 0);

      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0,
             $urandom_range(0, 31) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline register placed between core stages (fetch→decode→execute→memory→writeback). It carries one packed stage payload (e.g. `decode_data_t`) as a WIDTH-bit vector under a valid/ready handshake, with stall back-pressure, a synchronous flush for branch/exception squash, and a saturating stall-cycle counter. The fixed-enable, single-register stage latches are replaced by this block, one instance per stage boundary.

## Interface
- `WIDTH`, 32: payload width in bits; instantiate with `$bits(<stage struct>)`.
- `CNT_W`, 32: width of the stall-cycle counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  block can accept a payload this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  payload available to downstream.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  payload to downstream.
- `flush`  in  1  synchronous squash of every held payload.
- `occupancy`  out  2  number of held payloads (0..2; max 1 without skid).
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`, saturating.

## Operation
- Transfers: `in_fire = in_valid && in_ready`; `out_fire = out_valid && out_ready`.
- Ordering is strictly FIFO; no payload is duplicated or dropped except by `flush`.
- Skid mode states: `EMPTY` (0 held), `BUSY` (main held), `FULL` (main + skid held).
  - EMPTY: in_fire → BUSY, main ← in_data.
  - BUSY: in_fire & out_fire → BUSY, main ← in_data; in_fire & !out_fire → FULL, skid ← in_data; out_fire only → EMPTY.
  - FULL: no input accepted; out_fire → BUSY, main ← skid.
- `out_valid = (state != EMPTY)`; `out_data = main`; `in_ready = (state != FULL)`, derived from state only.
- `flush` has priority over everything: next state EMPTY, the input presented that cycle is dropped, and `out_fire` in the flush cycle still counts as delivered.
- `stall_cnt` increments by 1 each cycle with `out_valid && !out_ready`. It holds at all-ones and is cleared only by reset, not by flush.
- Unused data registers are never cleared after reset; only `out_valid` qualifies `out_data`.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `out_data`=0, `in_ready`=1, `occupancy`=0, `stall_cnt`=0; the skid register is also 0.
- Reset takes effect immediately on assertion. A payload mid-transfer is lost, and no `out_valid` is seen until the first in_fire after release.
- Latency: accepted at edge N → `out_valid` high after edge N, visible in cycle N+1.
- Throughput: 1 payload/cycle while `out_ready` is held high.
- Skid mode has no combinational path from `out_ready` to `in_ready`. The path from `in_valid` to `out_valid` is registered.
- `flush` asserted in cycle N → `out_valid`=0 and `occupancy`=0 in cycle N+1.

## Configuration
- `PIPE_SKID_EN` defined: the 2-entry skid behaviour above applies, `in_ready` is registered, and `occupancy` ranges 0..2.
- `PIPE_SKID_EN` undefined:
  - single register only; states EMPTY/BUSY.
  - `in_ready = !out_valid || out_ready` (combinational from `out_ready`).
  - `occupancy` ≤ 1.
  - all other behaviour is identical, including flush priority and the counter.

## Structure
- Package `pipes` gains `typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_t`.
- Package `pipes` gains `parameter PIPE_CNT_W = 32`.
- Stage structs stay in `pipes`. Instances pack and unpack them at the ports.
- Single module, no sub-modules. The counter is an always_ff block inside the module.

## Test plan
- Streaming, skid on: `out_ready`=1, feed 0x11,0x22,0x33 back-to-back → outputs 0x11,0x22,0x33 in cycles 2,3,4; `in_ready` is never 0; `stall_cnt`=0.
- Back-pressure: send 0xA0,0xA1 while `out_ready`=0 → `occupancy`=2, `in_ready`=0, 0xA2 is held upstream. Raise `out_ready` → 0xA0,0xA1,0xA2 in order, and `stall_cnt` equals the number of stalled cycles.
- Flush while FULL with `in_valid`=1 (0xBB) → next cycle `out_valid`=0, `occupancy`=0; 0xBB is never output.
- Asynchronous reset asserted mid-cycle while BUSY → outputs go to reset values before the next edge. After release, no output appears until new input.
- Saturation: `CNT_W`=4, stall 20 cycles → `stall_cnt`=15. A subsequent flush leaves it at 15.
- Skid off: `out_ready`=0 with a payload held → `in_ready`=0 in the same cycle. `out_ready`=1 with `in_valid`=1 → the output is consumed and the next payload is accepted at the same edge.
